// File: rtl/uart_rx_fifo.sv
// Oversampling 8N1 UART receiver (16x ticks, 3-sample majority vote) feeding a
// first-word-fall-through receive FIFO with sticky overrun/framing error flags.
module uart_rx_fifo #(
   parameter int unsigned BAUD_DIV   = 651,
   parameter int unsigned DEPTH_LOG2 = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  rx,
   input  logic                  rd_en,
   output logic [7:0]            rd_data,
   output logic                  empty,
   output logic                  full,
   output logic [DEPTH_LOG2:0]   count,
   output logic                  overrun,
   output logic                  frame_err,
   input  logic                  clr_err
);

   localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

   typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

   state_e                state_q;
   logic                  rx_meta_q, rx_sync_q, rx_prev_q;
   logic [15:0]           div_q;
   logic [3:0]            samp_q;
   logic [3:0]            bit_q;
   logic [1:0]            vote_q;
   logic [7:0]            shift_q;
   logic [7:0]            mem_q [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
   logic [DEPTH_LOG2:0]   count_q;
   logic                  overrun_q, frame_err_q;

   logic tick, start_det, bit_val, stop_tick, push, ferr_set, pop, push_ok;

   assign tick      = (div_q == 16'(BAUD_DIV - 1));
   assign start_det = (state_q == StIdle) && rx_prev_q && !rx_sync_q;
   // Samples 7 and 8 are stored; sample 9 is the live synced line.
   assign bit_val   = (vote_q[0] & vote_q[1]) | (vote_q[0] & rx_sync_q) |
                      (vote_q[1] & rx_sync_q);
   assign stop_tick = (state_q == StStop) && tick && (samp_q == 4'd9);
   assign push      = stop_tick && bit_val;
   assign ferr_set  = stop_tick && !bit_val;
   assign pop       = rd_en && !empty;
   assign push_ok   = push && (!full || pop);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_meta_q <= 1'b0;
         rx_sync_q <= 1'b0;
         rx_prev_q <= 1'b0;
         div_q     <= '0;
         samp_q    <= '0;
         bit_q     <= '0;
         vote_q    <= '0;
         shift_q   <= '0;
         state_q   <= StIdle;
      end else begin
         rx_meta_q <= rx;
         rx_sync_q <= rx_meta_q;
         rx_prev_q <= rx_sync_q;
         if (start_det || tick) div_q <= '0;
         else                   div_q <= div_q + 16'd1;

         if (state_q == StIdle) begin
            if (start_det) begin
               state_q <= StStart;
               samp_q  <= '0;
               bit_q   <= '0;
            end
         end else if (tick) begin
            samp_q <= samp_q + 4'd1;
            if (samp_q == 4'd7) vote_q[0] <= rx_sync_q;
            if (samp_q == 4'd8) vote_q[1] <= rx_sync_q;
            unique case (state_q)
               StStart: begin
                  if (samp_q == 4'd9 && bit_val) begin
                     state_q <= StIdle;
                  end else if (samp_q == 4'd15) begin
                     state_q <= StData;
                     bit_q   <= 4'd1;
                  end
               end
               StData: begin
                  if (samp_q == 4'd9) shift_q <= {bit_val, shift_q[7:1]};
                  if (samp_q == 4'd15) begin
                     if (bit_q == 4'd8) state_q <= StStop;
                     bit_q <= bit_q + 4'd1;
                  end
               end
               // Leave half a bit early so a back-to-back start edge is not missed.
               StStop: if (samp_q == 4'd9) state_q <= StIdle;
               StIdle: ;
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         overrun_q   <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         if (push_ok) begin
            mem_q[wr_ptr_q] <= shift_q;
            wr_ptr_q        <= wr_ptr_q + DEPTH_LOG2'(1);
         end
         if (pop) rd_ptr_q <= rd_ptr_q + DEPTH_LOG2'(1);
         if (push_ok && !pop)      count_q <= count_q + (DEPTH_LOG2+1)'(1);
         else if (!push_ok && pop) count_q <= count_q - (DEPTH_LOG2+1)'(1);

         // A new error event outranks a simultaneous clear.
         if (push && full && !pop) overrun_q <= 1'b1;
         else if (clr_err)         overrun_q <= 1'b0;
         if (ferr_set)             frame_err_q <= 1'b1;
         else if (clr_err)         frame_err_q <= 1'b0;
      end
   end

   assign rd_data   = mem_q[rd_ptr_q];
   assign count     = count_q;
   assign empty     = (count_q == '0);
   assign full      = (count_q == (DEPTH_LOG2+1)'(DEPTH));
   assign overrun   = overrun_q;
   assign frame_err = frame_err_q;

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Oversampling UART receiver with an 8-entry receive FIFO, placed between the board RX pin and the memory-mapped peripheral block. It replaces the single-byte receive register: it sync-samples the line, majority-votes three mid-bit samples, checks the stop bit, and queues received bytes so the CPU can drain bursts without losing characters. The peripheral block reads it through a first-word-fall-through pop interface and mirrors its status flags into UART_CON.

## Interface
- BAUD_DIV, 651: clk cycles per 1/16-bit sample tick (100 MHz / 9600 / 16); legal range 2..65535.
- DEPTH_LOG2, 3: log2 of FIFO depth (default 8 entries).
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low.
- rx  in  1  asynchronous serial line, idle high, 8N1, LSB first.
- rd_en  in  1  pop strobe, one entry per cycle when high and !empty.
- rd_data  out  8  head of FIFO, valid whenever !empty.
- empty  out  1  FIFO holds no bytes.
- full  out  1  FIFO holds 2^DEPTH_LOG2 bytes.
- count  out  DEPTH_LOG2+1  bytes currently held.
- overrun  out  1  sticky: a good byte was dropped because FIFO was full.
- frame_err  out  1  sticky: a stop bit sampled low.
- clr_err  in  1  one-cycle pulse clearing overrun and frame_err.

## Operation
- Reset values: rd_data 0, empty 1, full 0, count 0, overrun 0, frame_err 0; FSM IDLE; pointers 0.
- rx passes through a 2-flop synchronizer; both flops reset to 0. A start is an observed synced 1->0 transition, so a line held low through reset release is ignored until it goes high and falls again.
- Tick generator: counter reloaded to 0 on start detection, emits a one-cycle tick every BAUD_DIV clks; sample index s (0..15) and bit index b (0..9, 0=start, 1-8 data, 9=stop) advance on ticks.
- Bit value = majority of samples s=7,8,9 of that bit, evaluated on the s=9 tick.
- FSM states: IDLE, START, DATA, STOP.
- IDLE: on start detection -> START, s=0, b=0.
- START: at s=9, value 1 -> IDLE (glitch, nothing logged); value 0 -> continue; at s=15 tick -> DATA, b=1.
- DATA: at s=9 shift value into shift register LSB-first; at s=15 of b=8 -> STOP, else b+1.
- STOP: at s=9: value 1 -> push byte; value 0 -> set frame_err, drop byte. Either way -> IDLE on that tick (half-bit early to allow back-to-back frames).
- Push when full and no simultaneous pop: byte dropped, overrun set, FIFO unchanged.
- Simultaneous push and pop: both performed; count unchanged; applies also when full (push accepted) and when empty is false.
- Pop when empty: ignored, count stays 0, no underflow.
- clr_err coinciding with a new error event: the new error wins (flag stays 1).
- Pointers DEPTH_LOG2 bits, wrap modulo depth; full/empty derived from count.
- rx activity while FIFO full continues to be decoded; only the push is suppressed.

## Timing
- Start detection: 3 clks after rx falls (2 sync + edge register).
- Sample k of the frame (k = 16b + s) occurs (k+1)*BAUD_DIV clks after start detection; push on stop sample, k=153, i.e. 154*BAUD_DIV clks after detection.
- empty deasserts, count increments, rd_data valid in the clk after the push tick.
- rd_en sampled on clk edge; rd_data shows next entry (or empty asserts) the following cycle.
- frame_err / overrun rise the clk after the stop-sample tick; clear the clk after clr_err.
- Async reset mid-frame: immediate return to reset values; partial byte discarded.
- Minimum accepted frame spacing: stop bit half-length; the next start edge is detectable from the cycle after STOP->IDLE.

## Test plan
- BAUD_DIV=4, send 0xA5 8N1 -> empty falls 1 clk after sample 153, rd_data=0xA5, count=1; rd_en pulse -> empty=1, count=0.
- Send 10 back-to-back bytes 0x00..0x09 with no pops, DEPTH_LOG2=3 -> count=8, full=1, bytes 0x08,0x09 dropped, overrun=1; drain reads 0x00..0x07 in order.
- Send 0x3C with stop bit forced low -> frame_err=1, empty stays 1; clr_err pulse -> frame_err=0.
- 1-tick low glitch on idle line, and a start bit with only sample 8 low -> no byte, no error, FSM back in IDLE.
- Full FIFO with rd_en asserted in the push cycle -> count stays 8, overrun stays 0, new byte lands last.
- Hold rx low across reset release, then drive 0x55 after a high period -> only 0x55 received; assert reset mid-byte -> all outputs at reset values, next frame decoded correctly.
